fir_filter: RTL and testbench

// - Boxcar (moving-average) FIR: running sum of the last 2**TAPS_LOG2 samples; audio

---
 rtl/fir_filter.sv | 146 ++++++++++++++
 tb/tb_fir_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - boxcar moving-average FIR with aligned reference and high-pass outputs
// Define FIR_RAM_CLEAR_EN to zero the history RAM after every reset.
module fir_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS_LOG2  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic signed [DATA_WIDTH-1:0] high_pass_out,
  output logic signed [DATA_WIDTH-1:0] delayed_ref_out
);

  localparam int N     = 1 << TAPS_LOG2;
  localparam int ACC_W = DATA_WIDTH + TAPS_LOG2;
  localparam int HP_W  = DATA_WIDTH + 1;
  localparam logic [TAPS_LOG2-1:0] HALF = TAPS_LOG2'(N / 2);

`ifdef FIR_RAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, READ, CALC, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
  localparam logic [TAPS_LOG2-1:0] PTR_LAST = TAPS_LOG2'(N - 1);
`else
  typedef enum logic [1:0] {IDLE, READ, CALC} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state;
  state_t next_state;

  logic signed [DATA_WIDTH-1:0] ram [0:N-1];
  logic [TAPS_LOG2-1:0]         wr_ptr;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] sample_reg;
  logic signed [DATA_WIDTH-1:0] rd_old;
  logic signed [DATA_WIDTH-1:0] rd_ref;

  logic                         accept;
  logic                         calc;
  logic                         ram_we;
  logic signed [DATA_WIDTH-1:0] ram_wdata;
`ifdef FIR_RAM_CLEAR_EN
  logic                         clearing;
`endif

  logic signed [ACC_W-1:0]      new_acc;
  logic signed [DATA_WIDTH-1:0] new_avg;
  logic signed [HP_W-1:0]       hp_diff;
  logic signed [DATA_WIDTH-1:0] hp_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid) next_state = READ;
      READ:    next_state = CALC;
      CALC:    next_state = IDLE;
`ifdef FIR_RAM_CLEAR_EN
      CLEAR:   if (wr_ptr == PTR_LAST) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    calc   = 1'b0;
`ifdef FIR_RAM_CLEAR_EN
    clearing = 1'b0;
`endif
    case (state)
      IDLE: accept = sample_valid & ~rst;
      CALC: calc   = ~rst;
`ifdef FIR_RAM_CLEAR_EN
      CLEAR: clearing = ~rst;
`endif
      default: ;
    endcase
  end

`ifdef FIR_RAM_CLEAR_EN
  assign ram_we    = calc | clearing;
  assign ram_wdata = clearing ? '0 : sample_reg;
`else
  assign ram_we    = calc;
  assign ram_wdata = sample_reg;
`endif

  // Recursive running sum: drop the oldest sample, add the newest.
  always_comb begin
    new_acc = acc - ACC_W'(rd_old) + ACC_W'(sample_reg);
    new_avg = DATA_WIDTH'(new_acc >>> TAPS_LOG2);
    hp_diff = HP_W'(rd_ref) - HP_W'(new_avg);
    if (hp_diff[HP_W-1] != hp_diff[HP_W-2]) begin
      hp_sat = hp_diff[HP_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      hp_sat = hp_diff[DATA_WIDTH-1:0];
    end
  end

  // History RAM and its read registers carry no reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[wr_ptr] <= ram_wdata;
    end
    if (accept) begin
      sample_reg <= data_in;
      rd_old     <= ram[wr_ptr];
      rd_ref     <= ram[wr_ptr + HALF];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      wr_ptr          <= '0;
      data_out        <= '0;
      high_pass_out   <= '0;
      delayed_ref_out <= '0;
    end else begin
      if (calc) begin
        acc             <= new_acc;
        wr_ptr          <= wr_ptr + TAPS_LOG2'(1);
        data_out        <= new_avg;
        delayed_ref_out <= rd_ref;
        high_pass_out   <= hp_sat;
      end
`ifdef FIR_RAM_CLEAR_EN
      if (clearing) begin
        wr_ptr <= wr_ptr + TAPS_LOG2'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - scoreboard bench for fir_filter against a windowed-average model
module tb_fir_filter;
  localparam int DW   = 16;
  localparam int TL   = 7;
  localparam int N    = 128;
  localparam int HALF = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic signed [DW-1:0] data_out;
  logic signed [DW-1:0] high_pass_out;
  logic signed [DW-1:0] delayed_ref_out;

  fir_filter #(.DATA_WIDTH(DW), .TAPS_LOG2(TL)) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .data_in(data_in),
    .data_out(data_out),
    .high_pass_out(high_pass_out),
    .delayed_ref_out(delayed_ref_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lp;
    int dref;
    int hp;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accepted = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int floor_div_n(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Average of the last N accepted samples; history before reset is all zero.
  task automatic model_accept(input int x, input int due);
    exp_t e;
    int   sum;
    hist.push_back(x);
    void'(hist.pop_front());
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    e.lp   = floor_div_n(sum);
    e.dref = hist[N - 1 - HALF];
    e.hp   = clamp16(e.dref - e.lp);
    e.due  = due;
    exp_q.push_back(e);
    accepted++;
  endtask

  int hold_lp = 0;
  int hold_ref = 0;
  int hold_hp = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      hold_lp = 0;
      hold_ref = 0;
      hold_hp = 0;
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check("late_output", cyc, e.due);
      check("data_out", int'(data_out), e.lp);
      check("delayed_ref_out", int'(delayed_ref_out), e.dref);
      check("high_pass_out", int'(high_pass_out), e.hp);
      hold_lp = e.lp;
      hold_ref = e.dref;
      hold_hp = e.hp;
    end else begin
      check("hold_data_out", int'(data_out), hold_lp);
      check("hold_delayed_ref_out", int'(delayed_ref_out), hold_ref);
      check("hold_high_pass_out", int'(high_pass_out), hold_hp);
    end
  end

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    wait_drain();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    for (int i = 0; i < N; i++) dut.ram[i] <= '0;
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(0);
    accepted = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the next strobe may start.
  task automatic send(input int x);
    int extra;
    int gap;
    extra = int'($urandom_range(0, 2));
    gap   = int'($urandom_range(0, 3));
    sample_valid = 1'b1;
    data_in = DW'(x);
    model_accept(x, cyc + 3);
    for (int j = 1; j <= extra; j++) begin
      @(negedge clk);
      data_in = DW'($urandom);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2 - extra + gap) @(negedge clk);
  endtask

  // Strobe held high: only every third cycle lands in IDLE.
  task automatic send_held(input int n);
    int v;
    for (int k = 0; k < 3 * n; k++) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      sample_valid = 1'b1;
      data_in = DW'(v);
      if (k % 3 == 0) model_accept(v, cyc + 3);
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic check_ptr();
    wait_drain();
    check("wr_ptr", int'(dut.wr_ptr), accepted % N);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_data_out", int'(data_out), 0);
    check("reset_high_pass_out", int'(high_pass_out), 0);
    check("reset_delayed_ref_out", int'(delayed_ref_out), 0);
    repeat (20) @(negedge clk);
    check("idle_data_out", int'(data_out), 0);
    check("idle_ptr", int'(dut.wr_ptr), 0);

    send(12800);
    for (int k = 1; k < 200; k++) send(0);
    check_ptr();

    do_reset();
    for (int k = 0; k < 200; k++) send(4000);
    check_ptr();

    do_reset();
    for (int k = 0; k < 200; k++) send(-1);
    check_ptr();

    do_reset();
    for (int k = 0; k < 256; k++) send($rtoi(4000.0 * $sin(2.0 * 3.14159265358979 * k / 32.0)));
    check_ptr();

    do_reset();
    for (int k = 0; k < 130; k++) send(-32768);
    send(32767);
    for (int k = 0; k < 70; k++) send(-32768);
    for (int k = 0; k < 130; k++) send(32767);
    send(-32768);
    for (int k = 0; k < 70; k++) send(32767);
    check_ptr();

    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 7) send_held(4);
      else send(int'($urandom_range(0, 65535)) - 32768);
    end
    check_ptr();

    // Reset while a sample is in flight: no RAM write, pointer stays 0.
    do_reset();
    sample_valid = 1'b1;
    data_in = DW'(1234);
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_data_out", int'(data_out), 0);
    check("abort_ptr", int'(dut.wr_ptr), 0);
    check("abort_ram0", int'(dut.ram[0]), 0);
    @(negedge clk);
    for (int k = 0; k < 150; k++) send(int'($urandom_range(0, 65535)) - 32768);
    check_ptr();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
